midi_rx_parser: RTL and testbench
=================================

// Module: midi_rx_parser
// PURPOSE
// - Receives the MIDI IN serial line (31250 baud, 8N1) and assembles complete channel/system-common messages.
// - Sits upstream of the MIDI controller's learn path; delivers status/data1/data2/length with a one-cycle strobe.
// - Oversampled in the clk domain (no derived baud clock); implements running status and passes real-time bytes separately.
// PARAMETERS
// - CLKS_PER_BIT  3200  clk cycles per MIDI bit (100 MHz / 31250); must be even and >= 8
// - SYNC_STAGES   2     flip-flops in the midi_rx synchroniser (>= 2)
// PORTS
// - clk         in   1  system clock
// - rst         in   1  reset, asynchronous, active-low
// - midi_rx     in   1  raw MIDI IN line, idle high
// - msg_valid   out  1  one-cycle pulse: msg_* fields hold a new complete message
// - msg_status  out  8  status byte of the message
// - msg_data1   out  8  first data byte (0 if msg_len < 2)
// - msg_data2   out  8  second data byte (0 if msg_len < 3)
// - msg_len     out  2  message length in bytes incl. status: 1, 2 or 3
// - rt_valid    out  1  one-cycle pulse: real-time byte received
// - rt_byte     out  8  real-time byte (F8..FF)
// - frame_err   out  1  one-cycle pulse: stop bit sampled low
// - busy        out  1  high while receiver is not in IDLE
// BEHAVIOUR
// - Reset: all outputs 0; synchroniser flops = 1; receiver state BREAK; running status cleared.
// - Receiver FSM, states BREAK, IDLE, START, DATA, STOP; bit counter counts 0..CLKS_PER_BIT-1.
//   BREAK: wait for synced rx == 1, then go to IDLE.
//   IDLE: synced rx == 0 -> START, counter cleared.
//   START: at count CLKS_PER_BIT/2-1 sample rx; 0 -> DATA (counter cleared), 1 -> IDLE (glitch, nothing reported).
//   DATA: sample every CLKS_PER_BIT clocks (mid-bit), 8 bits, LSB first; after bit 7 -> STOP.
//   STOP: sample after CLKS_PER_BIT; 1 -> byte accepted, go to IDLE; 0 -> frame_err pulse, byte discarded, go to BREAK.
// - Latency: msg_valid / rt_valid / frame_err assert on the clock edge immediately after the stop-bit sample edge.
// - Parser: expected data count N is set by status byte:
//   8x 9x Ax Bx Ex -> 2; Cx Dx -> 1; F1 F3 -> 1; F2 -> 2; F6 -> 0; F0 -> enter SYSEX; F4 F5 F7 -> ignored.
//   Channel status (80..EF) becomes running status; F0..F7 clear running status.
//   F8..FF: rt_valid + rt_byte only; parser state, running status and partial message untouched (also inside SYSEX).
//   Data byte (00..7F): stored into data1 then data2; when count reaches N -> msg_valid, msg_len = N+1.
//   After completion, running status is kept and the count restarts: the next data byte begins a new message.
//   Status with N = 0 (F6) -> msg_valid on that byte, msg_len = 1.
//   Data byte with no running status -> dropped silently.
//   New status byte mid-message -> partial message discarded, no msg_valid.
//   SYSEX: all data bytes discarded; any status byte (F7 or other) exits SYSEX and is then handled normally.
// - msg_* and rt_byte hold their values until the next respective strobe; unused data fields forced to 0.
// - msg_valid and rt_valid are never asserted in the same cycle (one byte per stop bit).
// - Reset mid-byte or mid-message: everything cleared; the next frame is received only after the line has been seen high.
// TESTING (CLKS_PER_BIT = 16)
// - Send B0 2E 7F -> one msg_valid; status B0, data1 2E, data2 7F, len 3; no frame_err.
// - Send C0 42 then 43 -> two msg_valid; (C0,42,00,len 2) then (C0,43,00,len 2) via running status.
// - Send 90 3C F8 64 -> rt_valid with rt_byte F8 after byte 3; then msg (90,3C,64,len 3).
// - Byte 55 with stop bit 0, line low 3 bit times, then high, then send C0 10 -> one frame_err, no msg;
//   then msg (C0,10,00,2).
// - rx low for 3 clk (glitch) -> no strobe; then F0 01 02 F7 then 10 -> no msg_valid (sysex + orphan data dropped).
// - rst low during bit 4 of 90 -> all outputs 0; then send 80 40 00 -> msg (80,40,00,len 3).

Source files
------------

// File: rtl/midi_rx_parser.sv
// MIDI IN receiver and message assembler.
// Oversamples the raw MIDI line in the clk domain, deframes 8N1 bytes and
// builds channel / system-common messages with running status. Real-time
// bytes bypass the message assembler entirely.
//
// Receiver FSM
//   state | meaning
//   BREAK | line not yet seen high (after reset or framing error)
//   IDLE  | line high, waiting for a start-bit falling edge
//   START | validating the start bit at its midpoint
//   DATA  | sampling 8 data bits mid-bit, LSB first
//   STOP  | sampling the stop bit; high accepts the byte
module midi_rx_parser #(
    parameter int CLKS_PER_BIT = 3200,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_rx,
    output logic       msg_valid,
    output logic [7:0] msg_status,
    output logic [7:0] msg_data1,
    output logic [7:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_BREAK,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    rx_state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic                   cnt_clr, bit_take, stop_ok, stop_bad;
    logic                   byte_stb_q, ferr_stb_q, busy_q;

    // Parser context: the status currently accepting data bytes.
    logic [7:0] cur_status_q;
    logic [1:0] cur_need_q;
    logic       cur_active_q;
    logic       cur_chan_q;
    logic       have_d1_q;
    logic [7:0] cur_d1_q;

    logic [1:0] dec_need;
    logic       dec_open;
    logic       dec_chan;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign busy = busy_q;

    // Synchroniser for the asynchronous line; resets to the idle (high) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], midi_rx};
    end

    // Receiver state register plus registered busy that mirrors it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BREAK;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Receiver next-state and per-cycle control strobes.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        bit_take = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_clr = 1'b1;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_clr  = 1'b1;
                    bit_take = 1'b1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        stop_ok = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            default: state_d = S_BREAK;
        endcase
    end

    // Bit-period counter, bit index, shift register and byte-level strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            byte_stb_q <= 1'b0;
            ferr_stb_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_clr ? '0 : cnt_q + CW'(1);
            if (state_q != S_DATA) bit_idx_q <= 3'd0;
            else if (bit_take)     bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_take) shift_q <= {rx_s, shift_q[7:1]};
            byte_stb_q <= stop_ok;
            ferr_stb_q <= stop_bad;
        end
    end

    // Status decode: how many data bytes follow, and whether it is running status.
    always_comb begin
        dec_need = 2'd0;
        dec_open = 1'b0;
        dec_chan = 1'b0;
        if (shift_q < 8'hF0) begin
            dec_chan = 1'b1;
            dec_open = 1'b1;
            dec_need = (shift_q[7:4] == 4'hC || shift_q[7:4] == 4'hD) ? 2'd1 : 2'd2;
        end else begin
            case (shift_q)
                8'hF1, 8'hF3: begin dec_need = 2'd1; dec_open = 1'b1; end
                8'hF2:        begin dec_need = 2'd2; dec_open = 1'b1; end
                default:      ;
            endcase
        end
    end

    // Message assembly. F0 and other data-less statuses close the data slot,
    // so sysex payload and orphan data bytes fall through and are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_valid    <= 1'b0;
            msg_status   <= 8'h00;
            msg_data1    <= 8'h00;
            msg_data2    <= 8'h00;
            msg_len      <= 2'd0;
            rt_valid     <= 1'b0;
            rt_byte      <= 8'h00;
            frame_err    <= 1'b0;
            cur_status_q <= 8'h00;
            cur_need_q   <= 2'd0;
            cur_active_q <= 1'b0;
            cur_chan_q   <= 1'b0;
            have_d1_q    <= 1'b0;
            cur_d1_q     <= 8'h00;
        end else begin
            msg_valid <= 1'b0;
            rt_valid  <= 1'b0;
            frame_err <= ferr_stb_q;
            if (byte_stb_q) begin
                if (shift_q >= 8'hF8) begin
                    rt_valid <= 1'b1;
                    rt_byte  <= shift_q;
                end else if (shift_q[7]) begin
                    cur_status_q <= shift_q;
                    cur_need_q   <= dec_need;
                    cur_active_q <= dec_open;
                    cur_chan_q   <= dec_chan;
                    have_d1_q    <= 1'b0;
                    if (shift_q == 8'hF6) begin
                        msg_valid  <= 1'b1;
                        msg_status <= shift_q;
                        msg_data1  <= 8'h00;
                        msg_data2  <= 8'h00;
                        msg_len    <= 2'd1;
                    end
                end else if (cur_active_q) begin
                    if (!have_d1_q && cur_need_q == 2'd1) begin
                        msg_valid    <= 1'b1;
                        msg_status   <= cur_status_q;
                        msg_data1    <= shift_q;
                        msg_data2    <= 8'h00;
                        msg_len      <= 2'd2;
                        cur_active_q <= cur_chan_q;
                    end else if (!have_d1_q) begin
                        cur_d1_q  <= shift_q;
                        have_d1_q <= 1'b1;
                    end else begin
                        msg_valid    <= 1'b1;
                        msg_status   <= cur_status_q;
                        msg_data1    <= cur_d1_q;
                        msg_data2    <= shift_q;
                        msg_len      <= 2'd3;
                        have_d1_q    <= 1'b0;
                        cur_active_q <= cur_chan_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Self-checking bench for midi_rx_parser with a fast bit period.
module tb_midi_rx_parser;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       midi_rx = 1'b1;
    logic       msg_valid;
    logic [7:0] msg_status, msg_data1, msg_data2;
    logic [1:0] msg_len;
    logic       rt_valid;
    logic [7:0] rt_byte;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [25:0] obs_msg[$];
    logic [7:0]  obs_rt[$];
    int          obs_ferr = 0;
    int          obs_overlap = 0;

    // Reference model state.
    logic [25:0] exp_msg[$];
    logic [7:0]  exp_rt[$];
    logic [7:0]  m_pend[$];
    logic [7:0]  m_status;
    int          m_need;
    bit          m_keep;

    always #5 clk = ~clk;

    midi_rx_parser #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .midi_rx    (midi_rx),
        .msg_valid  (msg_valid),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .msg_len    (msg_len),
        .rt_valid   (rt_valid),
        .rt_byte    (rt_byte),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // Record every strobe seen, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (msg_valid) obs_msg.push_back({msg_status, msg_data1, msg_data2, msg_len});
            if (rt_valid)  obs_rt.push_back(rt_byte);
            if (frame_err) obs_ferr++;
            if (msg_valid && rt_valid) obs_overlap++;
        end
    end

    function automatic logic [25:0] pk(input logic [7:0] s, input logic [7:0] d1,
                                       input logic [7:0] d2, input logic [1:0] len);
        return {s, d1, d2, len};
    endfunction

    function automatic int needed(input logic [7:0] s);
        if (s < 8'hF0) return (s[7:4] == 4'hC || s[7:4] == 4'hD) ? 1 : 2;
        if (s == 8'hF1 || s == 8'hF3) return 1;
        if (s == 8'hF2) return 2;
        if (s == 8'hF6) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        exp_msg.delete();
        exp_rt.delete();
        m_pend.delete();
        m_status = 8'h00;
        m_need   = -1;
        m_keep   = 1'b0;
    endtask

    task automatic model_feed(input logic [7:0] b);
        if (b >= 8'hF8) begin
            exp_rt.push_back(b);
        end else if (b[7]) begin
            m_pend.delete();
            m_status = b;
            m_need   = needed(b);
            m_keep   = (b < 8'hF0);
            if (m_need == 0) begin
                exp_msg.push_back(pk(b, 8'h00, 8'h00, 2'd1));
                m_need = -1;
            end
        end else if (m_need > 0) begin
            m_pend.push_back(b);
            if (m_pend.size() == m_need) begin
                exp_msg.push_back(pk(m_status, m_pend[0], (m_need == 2) ? m_pend[1] : 8'h00,
                                     2'(m_need + 1)));
                m_pend.delete();
                if (!m_keep) m_need = -1;
            end
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_obs();
        obs_msg.delete();
        obs_rt.delete();
        obs_ferr    = 0;
        obs_overlap = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        midi_rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            wait_clks(CPB);
        end
        midi_rx = stop_bit;
        wait_clks(CPB);
        midi_rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        midi_rx = 1'b1;
        wait_clks(4);
        #1;
        n_cmp++;
        if ({msg_valid, msg_status, msg_data1, msg_data2, msg_len, rt_valid, rt_byte, frame_err, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h %h %h %h %h %h %h %h %h, want all 0",
                     msg_valid, msg_status, msg_data1, msg_data2, msg_len, rt_valid, rt_byte, frame_err, busy);
        end
        rst = 1'b1;
        wait_clks(10);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_full_msg();
        logic [25:0] want;
        clear_obs();
        want = pk(8'hB0, 8'h2E, 8'h7F, 2'd3);
        send_frame(8'hB0, 1'b1);
        send_frame(8'h2E, 1'b1);
        send_frame(8'h7F, 1'b1);
        wait_clks(20);
        n_cmp++;
        if (obs_msg.size() != 1 || obs_msg[0] !== want) begin
            n_err++;
            $display("FAIL full_msg: got %0d msgs first %h, want 1 msg %h", obs_msg.size(),
                     obs_msg.size() > 0 ? obs_msg[0] : 26'h0, want);
        end
        n_cmp++;
        if (obs_ferr != 0) begin
            n_err++;
            $display("FAIL full_msg_ferr: got %0d want 0", obs_ferr);
        end
        #1;
        n_cmp++;
        if ({msg_status, msg_data1, msg_data2, msg_len} !== want) begin
            n_err++;
            $display("FAIL full_msg_hold: got %h want %h", {msg_status, msg_data1, msg_data2, msg_len}, want);
        end
    endtask

    task automatic test_running_status();
        logic [25:0] want[2];
        clear_obs();
        want[0] = pk(8'hC0, 8'h42, 8'h00, 2'd2);
        want[1] = pk(8'hC0, 8'h43, 8'h00, 2'd2);
        send_frame(8'hC0, 1'b1);
        send_frame(8'h42, 1'b1);
        send_frame(8'h43, 1'b1);
        wait_clks(20);
        n_cmp++;
        if (obs_msg.size() != 2) begin
            n_err++;
            $display("FAIL running_count: got %0d want 2", obs_msg.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs_msg[i] !== want[i]) begin
                    n_err++;
                    $display("FAIL running_msg%0d: got %h want %h", i, obs_msg[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_realtime();
        logic [25:0] want;
        clear_obs();
        want = pk(8'h90, 8'h3C, 8'h64, 2'd3);
        send_frame(8'h90, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hF8, 1'b1);
        wait_clks(4);
        n_cmp++;
        if (obs_rt.size() != 1 || obs_rt[0] !== 8'hF8 || obs_msg.size() != 0) begin
            n_err++;
            $display("FAIL realtime_rt: got %0d rt (first %h), %0d msgs, want 1 rt F8, 0 msgs",
                     obs_rt.size(), obs_rt.size() > 0 ? obs_rt[0] : 8'h00, obs_msg.size());
        end
        send_frame(8'h64, 1'b1);
        wait_clks(20);
        n_cmp++;
        if (obs_msg.size() != 1 || obs_msg[0] !== want) begin
            n_err++;
            $display("FAIL realtime_msg: got %0d msgs first %h, want 1 msg %h", obs_msg.size(),
                     obs_msg.size() > 0 ? obs_msg[0] : 26'h0, want);
        end
        #1;
        n_cmp++;
        if (rt_byte !== 8'hF8) begin
            n_err++;
            $display("FAIL realtime_hold: got %h want F8", rt_byte);
        end
    endtask

    task automatic test_frame_error();
        logic [25:0] want;
        clear_obs();
        want = pk(8'hC0, 8'h10, 8'h00, 2'd2);
        send_frame(8'h55, 1'b0);
        midi_rx = 1'b0;
        wait_clks(3 * CPB);
        midi_rx = 1'b1;
        wait_clks(2 * CPB);
        n_cmp++;
        if (obs_ferr != 1 || obs_msg.size() != 0 || obs_rt.size() != 0) begin
            n_err++;
            $display("FAIL frame_err_pulse: got %0d ferr %0d msg %0d rt, want 1 0 0",
                     obs_ferr, obs_msg.size(), obs_rt.size());
        end
        send_frame(8'hC0, 1'b1);
        send_frame(8'h10, 1'b1);
        wait_clks(20);
        n_cmp++;
        if (obs_msg.size() != 1 || obs_msg[0] !== want || obs_ferr != 1) begin
            n_err++;
            $display("FAIL frame_err_recover: got %0d msgs first %h ferr %0d, want 1 msg %h ferr 1",
                     obs_msg.size(), obs_msg.size() > 0 ? obs_msg[0] : 26'h0, obs_ferr, want);
        end
    endtask

    task automatic test_glitch_sysex();
        clear_obs();
        midi_rx = 1'b0;
        wait_clks(3);
        midi_rx = 1'b1;
        wait_clks(2);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy: got %b want 1", busy);
        end
        wait_clks(3 * CPB);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || obs_msg.size() != 0 || obs_rt.size() != 0 || obs_ferr != 0) begin
            n_err++;
            $display("FAIL glitch_quiet: busy %b msgs %0d rt %0d ferr %0d, want 0 0 0 0",
                     busy, obs_msg.size(), obs_rt.size(), obs_ferr);
        end
        send_frame(8'hF0, 1'b1);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'hF7, 1'b1);
        send_frame(8'h10, 1'b1);
        wait_clks(20);
        n_cmp++;
        if (obs_msg.size() != 0 || obs_ferr != 0) begin
            n_err++;
            $display("FAIL sysex_drop: got %0d msgs %0d ferr, want 0 0", obs_msg.size(), obs_ferr);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0]  b;
        logic [25:0] want;
        clear_obs();
        want = pk(8'h80, 8'h40, 8'h00, 2'd3);
        b = 8'h90;
        send_frame(8'hC0, 1'b1);
        midi_rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            midi_rx = b[i];
            wait_clks(CPB);
        end
        midi_rx = b[4];
        wait_clks(CPB / 2);
        #2;
        rst = 1'b0;
        #2;
        n_cmp++;
        if ({msg_valid, msg_status, msg_data1, msg_data2, msg_len, rt_valid, rt_byte, frame_err, busy} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h %h %h %h %h %h %h %h %h, want all 0",
                     msg_valid, msg_status, msg_data1, msg_data2, msg_len, rt_valid, rt_byte, frame_err, busy);
        end
        wait_clks(CPB / 2);
        for (int i = 5; i < 8; i++) begin
            midi_rx = b[i];
            wait_clks(CPB);
        end
        midi_rx = 1'b1;
        wait_clks(CPB);
        rst = 1'b1;
        wait_clks(CPB);
        clear_obs();
        send_frame(8'h40, 1'b1);
        send_frame(8'h80, 1'b1);
        send_frame(8'h40, 1'b1);
        send_frame(8'h00, 1'b1);
        wait_clks(20);
        n_cmp++;
        if (obs_msg.size() != 1 || obs_msg[0] !== want || obs_rt.size() != 0) begin
            n_err++;
            $display("FAIL midreset_recover: got %0d msgs first %h rt %0d, want 1 msg %h rt 0",
                     obs_msg.size(), obs_msg.size() > 0 ? obs_msg[0] : 26'h0, obs_rt.size(), want);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         kind;
        // F7 clears any running status the DUT carries from earlier tests.
        send_frame(8'hF7, 1'b1);
        wait_clks(20);
        clear_obs();
        model_reset();
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3, 9: b = 8'($urandom_range(8'h00, 8'h7F));
                4, 5:          b = 8'($urandom_range(8'h80, 8'hEF));
                6:             b = 8'($urandom_range(8'hF8, 8'hFF));
                7:             b = 8'hF0;
                default:       b = 8'($urandom_range(8'hF1, 8'hF7));
            endcase
            send_frame(b, 1'b1);
            model_feed(b);
            wait_clks($urandom_range(0, 12));
        end
        wait_clks(20);
        n_cmp++;
        if (obs_msg.size() != exp_msg.size()) begin
            n_err++;
            $display("FAIL random_msg_count: got %0d want %0d", obs_msg.size(), exp_msg.size());
        end else begin
            foreach (exp_msg[i]) begin
                n_cmp++;
                if (obs_msg[i] !== exp_msg[i]) begin
                    n_err++;
                    $display("FAIL random_msg%0d: got %h want %h", i, obs_msg[i], exp_msg[i]);
                end
            end
        end
        n_cmp++;
        if (obs_rt.size() != exp_rt.size()) begin
            n_err++;
            $display("FAIL random_rt_count: got %0d want %0d", obs_rt.size(), exp_rt.size());
        end else begin
            foreach (exp_rt[i]) begin
                n_cmp++;
                if (obs_rt[i] !== exp_rt[i]) begin
                    n_err++;
                    $display("FAIL random_rt%0d: got %h want %h", i, obs_rt[i], exp_rt[i]);
                end
            end
        end
        n_cmp++;
        if (obs_overlap != 0 || obs_ferr != 0) begin
            n_err++;
            $display("FAIL random_overlap_ferr: got %0d overlaps %0d ferr, want 0 0", obs_overlap, obs_ferr);
        end
        if (exp_msg.size() > 0) begin
            #1;
            n_cmp++;
            if ({msg_status, msg_data1, msg_data2, msg_len} !== exp_msg[exp_msg.size()-1]) begin
                n_err++;
                $display("FAIL random_hold: got %h want %h", {msg_status, msg_data1, msg_data2, msg_len},
                         exp_msg[exp_msg.size()-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_msg();
        test_running_status();
        test_realtime();
        test_frame_error();
        test_glitch_sysex();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
